quiz_response_scorer: RTL and testbench
=======================================

Name: quiz_response_scorer

Overview:
- Datapath-side responder to the quiz game control FSM, for three players (A, B, C).
- Consumes the FSM's per-question strobes (cctenable, ld_game, question_selection, endgame) and per-player buzzer/answer inputs.
- Latches each player's first answer and response time per question, then scores at question close (correct answer plus a fastest-finger bonus).
- At end of game, produces a sequentially computed 1st/2nd/3rd ranking for the VGA ranking display.

Parameters:
TIME_W, 12, width of per-question response-time counter in tick_ms units; saturates at 2^TIME_W-1
NUM_Q, 5, number of questions per game; question_selection values 0..NUM_Q-1 are valid

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
tick_ms  input  1  one-cycle strobe every 1 ms
cctenable  input  1  high while a question is open (timer running)
ld_game  input  1  clear strobe from control; acts as "new game" only when question_selection==3'b111
question_selection  input  3  current question index; 3'b111 = no question
endgame  input  1  high in ranking state; triggers ranking
correct_ans  input  2  correct option for the current question
press_a, press_b, press_c  input  1  synchronised, debounced single-cycle buzzer pulses
ans_a, ans_b, ans_c  input  2  answer option selected by each player, sampled on press
locked  output  3  {C,B,A} player has answered the current question
first_correct  output  2  0=A, 1=B, 2=C, 3=none; first correct responder of last closed question
score_a, score_b, score_c  output  4  accumulated scores
time_a, time_b, time_c  output  TIME_W+3  accumulated response time over correct answers
rank1, rank2, rank3  output  2  player index per place, 3 = invalid
rank_valid  output  1  ranking outputs stable

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; all scores/times/locks/per-question latches 0; first_correct=3; rank1..3=3; rank_valid=0. Overrides every other input, including mid-question and mid-ranking.
- States: IDLE, OPEN, CLOSE, RANK1, RANK2, RANK3, DONE.
- IDLE:
  - ld_game && question_selection==7 clears scores, times, first_correct, ranks and rank_valid.
  - cctenable rising (registered previous value 0, current 1) with question_selection<NUM_Q -> OPEN. Same cycle: clear locked, latched answers, qtime counter and first-correct latch.
- OPEN:
  - qtime increments on each tick_ms, saturating.
  - press_x with locked[x]==0: latch ans_x and the current qtime value, set locked[x]. Later presses by that player are ignored.
  - Presses while not in OPEN are ignored.
  - First-correct latch: the first cycle with one or more correct presses records the winner. On simultaneous correct presses, priority A>B>C. Only the first such cycle counts.
  - cctenable low -> CLOSE.
- CLOSE (exactly one cycle), per player with locked and answer==correct_ans:
  - score += 1, plus 1 more if that player is the first-correct player.
  - time += latched qtime.
  - Scores saturate at 15; times saturate at all-ones.
  - first_correct output updated.
  - Next state IDLE.
- endgame high in IDLE or CLOSE -> RANK1 (CLOSE scoring is applied first).
- Ranking: three compare-swap cycles over the order list initialised to {A,B,C}.
  - RANK1 compares slots 0/1, RANK2 compares slots 1/2, RANK3 compares slots 0/1.
  - "Better" means higher score; on equal score, lower total time; on full tie, lower player index.
  - Swap when the later slot is better.
- DONE: rank1..3 driven from slots 0..2; rank_valid=1 from the cycle after RANK3, i.e. 3 cycles after entering RANK1.
  - Hold while endgame stays high.
  - endgame low -> IDLE with rank_valid cleared; scores are held until the next new-game clear.
- question_selection>=NUM_Q with cctenable rising: no transition (stay IDLE).
- cctenable rising while already in OPEN: ignored.
- tick_ms and press in the same cycle: press latches the pre-increment qtime.

Optional Feature:
- Macro WRONG_PENALTY_EN.
- Defined: in CLOSE, a locked player whose answer is wrong has score -= 1, saturating at 0; time is unaffected.
- Undefined: wrong or missing answers leave score unchanged.

Test Plan:
- Q0, correct_ans=2:
  - Stimulus: B presses ans=2 after 5 ticks, A presses ans=2 after 9 ticks, C presses ans=1, then cctenable falls.
  - Response: score_b=2, score_a=1, score_c=0, time_b=5, time_a=9, first_correct=1.
- Simultaneous presses:
  - Stimulus: A and C press the correct answer in the same cycle.
  - Response: first_correct=0, score_a=2, score_c=1.
- Double press and saturation:
  - Stimulus: A presses wrong then correct; separately, 5000 ticks elapse with TIME_W=12.
  - Response: second press ignored; qtime saturates at 4095.
- Ranking tie-break:
  - Stimulus: final scores A=4, B=4, C=6, time_a=30, time_b=20, then endgame.
  - Response: after 3 cycles rank1=2, rank2=1, rank3=0, rank_valid=1; endgame low -> rank_valid=0.
- Reset during OPEN with locks set:
  - Response: next cycle locked=0, scores=0, state IDLE; subsequent presses ignored until cctenable rises again.
- With WRONG_PENALTY_EN:
  - Stimulus: player at score 0 answers wrong.
  - Response: score stays 0; at score 3 a wrong answer gives 2.

Source files
------------

// File: rtl/quiz_response_scorer.sv
// Per-question answer latch, close-time scoring and end-of-game ranking for three quiz players.
// Build option WRONG_PENALTY_EN: a locked wrong answer costs one point, floored at 0.
module quiz_response_scorer #(
    parameter int TIME_W = 12,
    parameter int NUM_Q  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_ms,
    input  logic              cctenable,
    input  logic              ld_game,
    input  logic [2:0]        question_selection,
    input  logic              endgame,
    input  logic [1:0]        correct_ans,
    input  logic              press_a,
    input  logic              press_b,
    input  logic              press_c,
    input  logic [1:0]        ans_a,
    input  logic [1:0]        ans_b,
    input  logic [1:0]        ans_c,
    output logic [2:0]        locked,
    output logic [1:0]        first_correct,
    output logic [3:0]        score_a,
    output logic [3:0]        score_b,
    output logic [3:0]        score_c,
    output logic [TIME_W+2:0] time_a,
    output logic [TIME_W+2:0] time_b,
    output logic [TIME_W+2:0] time_c,
    output logic [1:0]        rank1,
    output logic [1:0]        rank2,
    output logic [1:0]        rank3,
    output logic              rank_valid
);
    localparam int TT_W = TIME_W + 3;
    localparam logic [2:0][1:0] ORDER_INIT = {2'd2, 2'd1, 2'd0};
    localparam logic [2:0][1:0] RANK_NONE  = {2'd3, 2'd3, 2'd3};

    typedef enum logic [2:0] {IDLE, OPEN, CLOSE, RANK1, RANK2, RANK3, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   cct_q;
    logic [TIME_W-1:0]      qtime_q;
    logic [2:0]             lock_q;
    logic [2:0][1:0]        ans_q;
    logic [2:0][TIME_W-1:0] lt_q;
    logic [1:0]             fc_q, first_q;
    logic [2:0][3:0]        score_q, score_nx;
    logic [2:0][TT_W-1:0]   time_q, time_nx;
    logic [2:0][1:0]        order_q, order_sw, rank_q;
    logic                   rank_valid_q;

    logic [2:0]             press_v, take, hit;
    logic [2:0][1:0]        ans_in;
    logic                   cct_rise, new_game, q_ok, later_better, s0;
    logic [1:0]             winner, p_e, p_l;

    assign press_v  = {press_c, press_b, press_a};
    assign ans_in   = {ans_c, ans_b, ans_a};
    assign cct_rise = cctenable & ~cct_q;
    assign new_game = ld_game && (question_selection == 3'b111);
    assign q_ok     = int'(question_selection) < NUM_Q;
    assign take     = press_v & ~lock_q;

    for (genvar i = 0; i < 3; i++) begin : g_pl
        logic               corr, bonus;
        logic [4:0]         s_add;
        logic [TT_W:0]      t_add;
        logic [3:0]         score_n;
        logic [TT_W-1:0]    time_n;

        assign hit[i] = take[i] && (ans_in[i] == correct_ans);
        assign corr   = lock_q[i] && (ans_q[i] == correct_ans);
        assign bonus  = (fc_q == 2'(i));
        assign s_add  = {1'b0, score_q[i]} + (bonus ? 5'd2 : 5'd1);
        assign t_add  = {1'b0, time_q[i]} + (TT_W+1)'(lt_q[i]);

        always_comb begin
            score_n = score_q[i];
            time_n  = time_q[i];
            if (corr) begin
                score_n = (s_add > 5'd15) ? 4'd15 : s_add[3:0];
                time_n  = t_add[TT_W] ? '1 : t_add[TT_W-1:0];
            end
`ifdef WRONG_PENALTY_EN
            else if (lock_q[i] && score_q[i] != 4'd0) begin
                score_n = score_q[i] - 4'd1;
            end
`endif
        end

        assign score_nx[i] = score_n;
        assign time_nx[i]  = time_n;
    end

    // Simultaneous correct presses resolve A > B > C.
    always_comb begin
        winner = 2'd3;
        if (hit[0])      winner = 2'd0;
        else if (hit[1]) winner = 2'd1;
        else if (hit[2]) winner = 2'd2;
    end

    // RANK2 compares slots 1/2; RANK1 and RANK3 compare slots 0/1.
    assign s0  = (state_q == RANK2);
    assign p_e = s0 ? order_q[1] : order_q[0];
    assign p_l = s0 ? order_q[2] : order_q[1];
    assign later_better = (score_q[p_l] > score_q[p_e]) ||
                          ((score_q[p_l] == score_q[p_e]) &&
                           ((time_q[p_l] < time_q[p_e]) ||
                            ((time_q[p_l] == time_q[p_e]) && (p_l < p_e))));

    always_comb begin
        order_sw = order_q;
        if (later_better) begin
            if (s0) begin
                order_sw[1] = order_q[2];
                order_sw[2] = order_q[1];
            end else begin
                order_sw[0] = order_q[1];
                order_sw[1] = order_q[0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (endgame)               state_d = RANK1;
                else if (cct_rise && q_ok) state_d = OPEN;
            end
            OPEN:    if (!cctenable) state_d = CLOSE;
            CLOSE:   state_d = endgame ? RANK1 : IDLE;
            RANK1:   state_d = RANK2;
            RANK2:   state_d = RANK3;
            RANK3:   state_d = DONE;
            DONE:    if (!endgame) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Edge detector keeps sampling through reset so a held cctenable does not reopen a question.
    always_ff @(posedge clk) cct_q <= cctenable;

    always_ff @(posedge clk) begin
        if (!reset) begin
            qtime_q      <= '0;
            lock_q       <= '0;
            ans_q        <= '0;
            lt_q         <= '0;
            fc_q         <= 2'd3;
            first_q      <= 2'd3;
            score_q      <= '0;
            time_q       <= '0;
            order_q      <= ORDER_INIT;
            rank_q       <= RANK_NONE;
            rank_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (new_game) begin
                        score_q      <= '0;
                        time_q       <= '0;
                        first_q      <= 2'd3;
                        rank_q       <= RANK_NONE;
                        rank_valid_q <= 1'b0;
                    end
                    if (state_d == OPEN) begin
                        lock_q  <= '0;
                        ans_q   <= '0;
                        lt_q    <= '0;
                        qtime_q <= '0;
                        fc_q    <= 2'd3;
                    end
                    if (state_d == RANK1) order_q <= ORDER_INIT;
                end
                OPEN: begin
                    if (tick_ms && qtime_q != '1) qtime_q <= qtime_q + 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        if (take[i]) begin
                            lock_q[i] <= 1'b1;
                            ans_q[i]  <= ans_in[i];
                            lt_q[i]   <= qtime_q;
                        end
                    end
                    if (fc_q == 2'd3 && winner != 2'd3) fc_q <= winner;
                end
                CLOSE: begin
                    score_q <= score_nx;
                    time_q  <= time_nx;
                    first_q <= fc_q;
                    if (state_d == RANK1) order_q <= ORDER_INIT;
                end
                RANK1, RANK2: order_q <= order_sw;
                RANK3: begin
                    order_q      <= order_sw;
                    rank_q       <= order_sw;
                    rank_valid_q <= 1'b1;
                end
                DONE: if (!endgame) rank_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign locked        = lock_q;
    assign first_correct = first_q;
    assign score_a       = score_q[0];
    assign score_b       = score_q[1];
    assign score_c       = score_q[2];
    assign time_a        = time_q[0];
    assign time_b        = time_q[1];
    assign time_c        = time_q[2];
    assign rank1         = rank_q[0];
    assign rank2         = rank_q[1];
    assign rank3         = rank_q[2];
    assign rank_valid    = rank_valid_q;
endmodule

// File: tb/tb_quiz_response_scorer.sv
// Self-checking bench for quiz_response_scorer: directed scenarios plus randomized games vs a reference model.
module tb_quiz_response_scorer;
    localparam int TIME_W = 12;
    localparam int NUM_Q  = 5;
    localparam int TMAX   = 4095;
    localparam int TTMAX  = 32767;

    logic clk = 1'b0;
    logic reset, tick_ms, cctenable, ld_game, endgame;
    logic [2:0] question_selection;
    logic [1:0] correct_ans, ans_a, ans_b, ans_c;
    logic press_a, press_b, press_c;
    logic [2:0] locked;
    logic [1:0] first_correct, rank1, rank2, rank3;
    logic [3:0] score_a, score_b, score_c;
    logic [TIME_W+2:0] time_a, time_b, time_c;
    logic rank_valid;

    always #5 clk = ~clk;

    quiz_response_scorer #(.TIME_W(TIME_W), .NUM_Q(NUM_Q)) dut (
        .clk(clk), .reset(reset), .tick_ms(tick_ms), .cctenable(cctenable), .ld_game(ld_game),
        .question_selection(question_selection), .endgame(endgame), .correct_ans(correct_ans),
        .press_a(press_a), .press_b(press_b), .press_c(press_c),
        .ans_a(ans_a), .ans_b(ans_b), .ans_c(ans_c),
        .locked(locked), .first_correct(first_correct),
        .score_a(score_a), .score_b(score_b), .score_c(score_c),
        .time_a(time_a), .time_b(time_b), .time_c(time_c),
        .rank1(rank1), .rank2(rank2), .rank3(rank3), .rank_valid(rank_valid)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model state: game totals plus the currently open question.
    int m_score[3], m_time[3], m_fc_out;
    bit m_open;
    int m_ca, q_ticks, q_fc;
    bit q_lock[3];
    int q_ans[3], q_t[3];

    function automatic int dut_score(int p);
        case (p)
            0: return int'(score_a);
            1: return int'(score_b);
            default: return int'(score_c);
        endcase
    endfunction

    function automatic int dut_time(int p);
        case (p)
            0: return int'(time_a);
            1: return int'(time_b);
            default: return int'(time_c);
        endcase
    endfunction

    function automatic int dut_rank(int k);
        case (k)
            0: return int'(rank1);
            1: return int'(rank2);
            default: return int'(rank3);
        endcase
    endfunction

    function automatic bit m_better(int x, int y);
        if (m_score[x] != m_score[y]) return m_score[x] > m_score[y];
        if (m_time[x] != m_time[y])   return m_time[x] < m_time[y];
        return x < y;
    endfunction

    function automatic int m_place(int k);
        bit used[3];
        int pick;
        used = '{0, 0, 0};
        pick = 0;
        for (int place = 0; place <= k; place++) begin
            pick = -1;
            for (int p = 0; p < 3; p++)
                if (!used[p] && (pick < 0 || m_better(p, pick))) pick = p;
            used[pick] = 1;
        end
        return pick;
    endfunction

    task automatic model_clear_game();
        for (int p = 0; p < 3; p++) begin
            m_score[p] = 0;
            m_time[p]  = 0;
        end
        m_fc_out = 3;
    endtask

    task automatic cyc(input bit tk, input bit [2:0] pr, input logic [1:0] aa, input logic [1:0] ab, input logic [1:0] ac);
        logic [1:0] a [3];
        int w;
        a[0] = aa; a[1] = ab; a[2] = ac;
        tick_ms = tk;
        press_a = pr[0]; press_b = pr[1]; press_c = pr[2];
        ans_a = aa; ans_b = ab; ans_c = ac;
        if (m_open) begin
            w = 3;
            for (int p = 0; p < 3; p++) begin
                if (pr[p] && !q_lock[p]) begin
                    q_lock[p] = 1;
                    q_ans[p]  = int'(a[p]);
                    q_t[p]    = q_ticks;
                    if (int'(a[p]) == m_ca && w == 3) w = p;
                end
            end
            if (q_fc == 3) q_fc = w;
            if (tk && q_ticks < TMAX) q_ticks++;
        end
        @(posedge clk);
        #1;
        tick_ms = 0; press_a = 0; press_b = 0; press_c = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1, 3'b000, 2'd0, 2'd0, 2'd0);
    endtask

    task automatic new_game();
        question_selection = 3'b111;
        ld_game = 1;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        ld_game = 0;
        model_clear_game();
    endtask

    task automatic open_q(input int qs, input int ca);
        question_selection = 3'(qs);
        correct_ans = 2'(ca);
        cctenable = 1;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        m_open = 1; m_ca = ca; q_ticks = 0; q_fc = 3;
        for (int p = 0; p < 3; p++) begin
            q_lock[p] = 0; q_ans[p] = 0; q_t[p] = 0;
        end
    endtask

    task automatic close_q(input bit eg);
        cctenable = 0;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        endgame = eg;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        m_open = 0;
        for (int p = 0; p < 3; p++) begin
            if (q_lock[p] && q_ans[p] == m_ca) begin
                m_score[p] += (q_fc == p) ? 2 : 1;
                if (m_score[p] > 15) m_score[p] = 15;
                m_time[p] += q_t[p];
                if (m_time[p] > TTMAX) m_time[p] = TTMAX;
            end
`ifdef WRONG_PENALTY_EN
            else if (q_lock[p] && m_score[p] > 0) m_score[p]--;
`endif
        end
        m_fc_out = q_fc;
    endtask

    task automatic test_reset();
        reset = 0; tick_ms = 0; cctenable = 0; ld_game = 0; endgame = 0;
        question_selection = 3'b111; correct_ans = 0;
        press_a = 0; press_b = 0; press_c = 0; ans_a = 0; ans_b = 0; ans_c = 0;
        m_open = 0;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        reset = 1;
        model_clear_game();
        chk_cnt++; if (locked !== 3'b000) $display("FAIL reset_locked got=%b exp=000", locked); else pass_cnt++;
        chk_cnt++; if (first_correct !== 2'd3) $display("FAIL reset_fc got=%0d exp=3", first_correct); else pass_cnt++;
        chk_cnt++; if ({score_a, score_b, score_c} !== 12'd0) $display("FAIL reset_scores got=%h exp=0", {score_a, score_b, score_c}); else pass_cnt++;
        chk_cnt++; if ({time_a, time_b, time_c} !== 45'd0) $display("FAIL reset_times got=%h exp=0", {time_a, time_b, time_c}); else pass_cnt++;
        chk_cnt++; if ({rank1, rank2, rank3} !== 6'b111111) $display("FAIL reset_ranks got=%b exp=111111", {rank1, rank2, rank3}); else pass_cnt++;
        chk_cnt++; if (rank_valid !== 1'b0) $display("FAIL reset_rank_valid got=%b exp=0", rank_valid); else pass_cnt++;
    endtask

    task automatic test_q0_directed();
        new_game();
        open_q(0, 2);
        ticks(5);
        cyc(0, 3'b010, 2'd0, 2'd2, 2'd0);
        ticks(4);
        cyc(0, 3'b001, 2'd2, 2'd0, 2'd0);
        cyc(0, 3'b100, 2'd0, 2'd0, 2'd1);
        chk_cnt++; if (locked !== 3'b111) $display("FAIL q0_locked got=%b exp=111", locked); else pass_cnt++;
        close_q(0);
        chk_cnt++; if (score_b !== 4'd2) $display("FAIL q0_score_b got=%0d exp=2", score_b); else pass_cnt++;
        chk_cnt++; if (score_a !== 4'd1) $display("FAIL q0_score_a got=%0d exp=1", score_a); else pass_cnt++;
        chk_cnt++; if (score_c !== 4'd0) $display("FAIL q0_score_c got=%0d exp=0", score_c); else pass_cnt++;
        chk_cnt++; if (time_b !== 15'd5) $display("FAIL q0_time_b got=%0d exp=5", time_b); else pass_cnt++;
        chk_cnt++; if (time_a !== 15'd9) $display("FAIL q0_time_a got=%0d exp=9", time_a); else pass_cnt++;
        chk_cnt++; if (first_correct !== 2'd1) $display("FAIL q0_first_correct got=%0d exp=1", first_correct); else pass_cnt++;
    endtask

    // A and C correct in the same cycle, with a tick in that cycle too.
    task automatic test_simultaneous();
        new_game();
        open_q(1, 3);
        ticks(3);
        cyc(1, 3'b101, 2'd3, 2'd0, 2'd3);
        close_q(0);
        chk_cnt++; if (first_correct !== 2'd0) $display("FAIL simul_fc got=%0d exp=0", first_correct); else pass_cnt++;
        chk_cnt++; if (score_a !== 4'd2) $display("FAIL simul_score_a got=%0d exp=2", score_a); else pass_cnt++;
        chk_cnt++; if (score_c !== 4'd1) $display("FAIL simul_score_c got=%0d exp=1", score_c); else pass_cnt++;
        chk_cnt++; if (time_c !== 15'd3) $display("FAIL simul_time_c got=%0d exp=3", time_c); else pass_cnt++;
    endtask

    task automatic test_double_press_sat();
        new_game();
        open_q(2, 1);
        cyc(0, 3'b001, 2'd0, 2'd0, 2'd0);
        ticks(2);
        cyc(0, 3'b001, 2'd1, 2'd0, 2'd0);
        ticks(5000);
        cyc(0, 3'b010, 2'd0, 2'd1, 2'd0);
        chk_cnt++; if (locked !== 3'b011) $display("FAIL dbl_locked got=%b exp=011", locked); else pass_cnt++;
        close_q(0);
        chk_cnt++; if (score_a !== 4'd0) $display("FAIL dbl_score_a got=%0d exp=0", score_a); else pass_cnt++;
        chk_cnt++; if (time_a !== 15'd0) $display("FAIL dbl_time_a got=%0d exp=0", time_a); else pass_cnt++;
        chk_cnt++; if (score_b !== 4'd2) $display("FAIL sat_score_b got=%0d exp=2", score_b); else pass_cnt++;
        chk_cnt++; if (time_b !== 15'd4095) $display("FAIL sat_time_b got=%0d exp=4095", time_b); else pass_cnt++;
    endtask

    // Out-of-range question index must not open; locks from the last question stay.
    task automatic test_invalid_q();
        question_selection = 3'd5;
        cctenable = 1;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        cyc(0, 3'b100, 2'd0, 2'd0, 2'd1);
        cctenable = 0;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        chk_cnt++; if (locked !== 3'b011) $display("FAIL invq_locked got=%b exp=011", locked); else pass_cnt++;
        chk_cnt++; if (score_b !== 4'd2) $display("FAIL invq_score_b got=%0d exp=2", score_b); else pass_cnt++;
    endtask

    task automatic test_rank_tiebreak();
        new_game();
        open_q(0, 1);
        cyc(0, 3'b001, 2'd1, 2'd0, 2'd0);
        ticks(5);
        cyc(0, 3'b110, 2'd0, 2'd1, 2'd1);
        close_q(0);
        open_q(1, 2);
        ticks(5);
        cyc(0, 3'b010, 2'd0, 2'd2, 2'd0);
        ticks(5);
        cyc(0, 3'b101, 2'd2, 2'd0, 2'd2);
        close_q(0);
        open_q(2, 0);
        cyc(0, 3'b100, 2'd0, 2'd0, 2'd0);
        ticks(10);
        cyc(0, 3'b010, 2'd0, 2'd0, 2'd0);
        ticks(10);
        cyc(0, 3'b001, 2'd0, 2'd0, 2'd0);
        close_q(0);
        open_q(3, 3);
        cyc(0, 3'b100, 2'd0, 2'd0, 2'd3);
        close_q(1);
        chk_cnt++; if ({score_a, score_b, score_c} !== {4'd4, 4'd4, 4'd6}) $display("FAIL rank_scores got=%h exp=446", {score_a, score_b, score_c}); else pass_cnt++;
        chk_cnt++; if (time_a !== 15'd30 || time_b !== 15'd20) $display("FAIL rank_times got=%0d,%0d exp=30,20", time_a, time_b); else pass_cnt++;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        chk_cnt++; if (rank_valid !== 1'b0) $display("FAIL rank_valid_early got=%b exp=0", rank_valid); else pass_cnt++;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        chk_cnt++; if (rank_valid !== 1'b1) $display("FAIL rank_valid got=%b exp=1", rank_valid); else pass_cnt++;
        chk_cnt++; if ({rank1, rank2, rank3} !== {2'd2, 2'd1, 2'd0}) $display("FAIL rank_order got=%0d,%0d,%0d exp=2,1,0", rank1, rank2, rank3); else pass_cnt++;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        chk_cnt++; if (rank_valid !== 1'b1) $display("FAIL rank_hold got=%b exp=1", rank_valid); else pass_cnt++;
        endgame = 0;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        chk_cnt++; if (rank_valid !== 1'b0) $display("FAIL rank_release got=%b exp=0", rank_valid); else pass_cnt++;
        chk_cnt++; if (score_c !== 4'd6) $display("FAIL rank_score_held got=%0d exp=6", score_c); else pass_cnt++;
    endtask

    task automatic test_reset_open();
        new_game();
        open_q(0, 1);
        cyc(0, 3'b001, 2'd1, 2'd0, 2'd0);
        close_q(0);
        open_q(1, 0);
        cyc(0, 3'b011, 2'd0, 2'd0, 2'd0);
        chk_cnt++; if (locked !== 3'b011) $display("FAIL rstopen_pre_locked got=%b exp=011", locked); else pass_cnt++;
        m_open = 0;
        reset = 0;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        reset = 1;
        model_clear_game();
        chk_cnt++; if (locked !== 3'b000) $display("FAIL rstopen_locked got=%b exp=000", locked); else pass_cnt++;
        chk_cnt++; if (score_a !== 4'd0) $display("FAIL rstopen_score_a got=%0d exp=0", score_a); else pass_cnt++;
        cyc(0, 3'b001, 2'd0, 2'd0, 2'd0);
        chk_cnt++; if (locked !== 3'b000) $display("FAIL rstopen_ignored got=%b exp=000", locked); else pass_cnt++;
        cctenable = 0;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        open_q(2, 0);
        cyc(0, 3'b001, 2'd0, 2'd0, 2'd0);
        chk_cnt++; if (locked !== 3'b001) $display("FAIL rstopen_reopen got=%b exp=001", locked); else pass_cnt++;
        close_q(0);
        chk_cnt++; if (score_a !== 4'd2) $display("FAIL rstopen_score got=%0d exp=2", score_a); else pass_cnt++;
    endtask

`ifdef WRONG_PENALTY_EN
    task automatic test_penalty();
        new_game();
        open_q(0, 1);
        cyc(0, 3'b001, 2'd2, 2'd0, 2'd0);
        close_q(0);
        chk_cnt++; if (score_a !== 4'd0) $display("FAIL pen_floor got=%0d exp=0", score_a); else pass_cnt++;
        open_q(1, 1);
        cyc(0, 3'b001, 2'd1, 2'd0, 2'd0);
        close_q(0);
        open_q(2, 3);
        cyc(0, 3'b010, 2'd0, 2'd3, 2'd0);
        cyc(0, 3'b001, 2'd3, 2'd0, 2'd0);
        close_q(0);
        chk_cnt++; if (score_a !== 4'd3) $display("FAIL pen_setup got=%0d exp=3", score_a); else pass_cnt++;
        open_q(3, 0);
        cyc(0, 3'b001, 2'd1, 2'd0, 2'd0);
        close_q(0);
        chk_cnt++; if (score_a !== 4'd2) $display("FAIL pen_minus got=%0d exp=2", score_a); else pass_cnt++;
    endtask
`endif

    task automatic test_random();
        int n;
        bit tk;
        bit [2:0] pr;
        logic [2:0] exp_lock;
        new_game();
        for (int q = 0; q < 12; q++) begin
            open_q($urandom_range(0, NUM_Q-1), $urandom_range(0, 3));
            n = $urandom_range(5, 60);
            for (int c = 0; c < n; c++) begin
                tk = ($urandom_range(0, 2) == 0);
                pr = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
                cyc(tk, pr, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end
            exp_lock = {q_lock[2], q_lock[1], q_lock[0]};
            chk_cnt++; if (locked !== exp_lock) $display("FAIL rnd_locked q=%0d got=%b exp=%b", q, locked, exp_lock); else pass_cnt++;
            close_q(0);
            chk_cnt++; if (int'(first_correct) !== m_fc_out) $display("FAIL rnd_fc q=%0d got=%0d exp=%0d", q, first_correct, m_fc_out); else pass_cnt++;
            for (int p = 0; p < 3; p++) begin
                chk_cnt++; if (dut_score(p) !== m_score[p]) $display("FAIL rnd_score q=%0d p=%0d got=%0d exp=%0d", q, p, dut_score(p), m_score[p]); else pass_cnt++;
                chk_cnt++; if (dut_time(p) !== m_time[p]) $display("FAIL rnd_time q=%0d p=%0d got=%0d exp=%0d", q, p, dut_time(p), m_time[p]); else pass_cnt++;
            end
        end
        endgame = 1;
        repeat (4) cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
        chk_cnt++; if (rank_valid !== 1'b1) $display("FAIL rnd_rank_valid got=%b exp=1", rank_valid); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++; if (dut_rank(k) !== m_place(k)) $display("FAIL rnd_rank place=%0d got=%0d exp=%0d", k, dut_rank(k), m_place(k)); else pass_cnt++;
        end
        endgame = 0;
        cyc(0, 3'b000, 2'd0, 2'd0, 2'd0);
    endtask

    initial begin
        test_reset();
        test_q0_directed();
        test_simultaneous();
        test_double_press_sat();
        test_invalid_q();
        test_rank_tiebreak();
        test_reset_open();
`ifdef WRONG_PENALTY_EN
        test_penalty();
`endif
        test_random();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
